// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - requester and register-file signal bundle for regfile_arbiter
interface regfile_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req1_valid;
    logic          req0_ready;
    logic          req1_ready;
    logic          req0_lock;
    logic          req1_lock;
    logic          req0_we;
    logic          req1_we;
    logic [AW-1:0] req0_waddr;
    logic [AW-1:0] req1_waddr;
    logic [DW-1:0] req0_wdata;
    logic [DW-1:0] req1_wdata;
    logic [AW-1:0] req0_raddr1;
    logic [AW-1:0] req0_raddr2;
    logic [AW-1:0] req1_raddr1;
    logic [AW-1:0] req1_raddr2;
    logic          rsp0_valid;
    logic          rsp1_valid;
    logic [DW-1:0] rsp_rdata1;
    logic [DW-1:0] rsp_rdata2;
    logic [AW-1:0] rf_r1_addr;
    logic [AW-1:0] rf_r2_addr;
    logic [AW-1:0] rf_r3_addr;
    logic [DW-1:0] rf_r3_din;
    logic          rf_r3_wr;
    logic [DW-1:0] rf_r1_dout;
    logic [DW-1:0] rf_r2_dout;

    modport slave (
        input  req0_valid, req1_valid, req0_lock, req1_lock, req0_we, req1_we,
        input  req0_waddr, req1_waddr, req0_wdata, req1_wdata,
        input  req0_raddr1, req0_raddr2, req1_raddr1, req1_raddr2,
        input  rf_r1_dout, rf_r2_dout,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata1, rsp_rdata2,
        output rf_r1_addr, rf_r2_addr, rf_r3_addr, rf_r3_din, rf_r3_wr
    );

    modport master (
        output req0_valid, req1_valid, req0_lock, req1_lock, req0_we, req1_we,
        output req0_waddr, req1_waddr, req0_wdata, req1_wdata,
        output req0_raddr1, req0_raddr2, req1_raddr1, req1_raddr2,
        output rf_r1_dout, rf_r2_dout,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata1, rsp_rdata2,
        input  rf_r1_addr, rf_r2_addr, rf_r3_addr, rf_r3_din, rf_r3_wr
    );
endinterface

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester round-robin/lock arbiter for a 32x32 register file (optional RFARB_R0_GUARD_EN)
module regfile_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    regfile_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;
    logic          rsp0_q, rsp0_d;
    logic          rsp1_q, rsp1_d;
    logic [AW-1:0] raddr1_q, raddr1_d;
    logic [AW-1:0] raddr2_q, raddr2_d;

    logic          gnt0;
    logic          gnt1;
    logic          accept;
    logic          win;
    logic          win_lock;
    logic          win_we;
    logic [AW-1:0] win_waddr;
    logic [DW-1:0] win_wdata;
    logic [AW-1:0] win_raddr1;
    logic [AW-1:0] win_raddr2;

`ifdef RFARB_R0_GUARD_EN
    logic          zero1_q, zero1_d;
    logic          zero2_q, zero2_d;
`endif

    // Grant selection: lock owner only when locked, otherwise round-robin on contention
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_IDLE: begin
                    gnt0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
                    gnt1 = bus.req1_valid && (!bus.req0_valid || rr_q);
                end
                ST_LOCK0: gnt0 = bus.req0_valid;
                ST_LOCK1: gnt1 = bus.req1_valid;
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
        accept = gnt0 || gnt1;
        win    = gnt1;
    end

    // Winner request mux
    always_comb begin
        win_lock   = win ? bus.req1_lock   : bus.req0_lock;
        win_we     = win ? bus.req1_we     : bus.req0_we;
        win_waddr  = win ? bus.req1_waddr  : bus.req0_waddr;
        win_wdata  = win ? bus.req1_wdata  : bus.req0_wdata;
        win_raddr1 = win ? bus.req1_raddr1 : bus.req0_raddr1;
        win_raddr2 = win ? bus.req1_raddr2 : bus.req0_raddr2;
    end

    // Issue to the register file; read addresses hold between grants so read data stays stable
    always_comb begin
        bus.req0_ready = gnt0;
        bus.req1_ready = gnt1;
        raddr1_d       = accept ? win_raddr1 : raddr1_q;
        raddr2_d       = accept ? win_raddr2 : raddr2_q;
        bus.rf_r1_addr = rst_n ? raddr1_d : '0;
        bus.rf_r2_addr = rst_n ? raddr2_d : '0;
        bus.rf_r3_addr = accept ? win_waddr : '0;
        bus.rf_r3_din  = accept ? win_wdata : '0;
`ifdef RFARB_R0_GUARD_EN
        bus.rf_r3_wr   = accept && win_we && (win_waddr != '0);
`else
        bus.rf_r3_wr   = accept && win_we;
`endif
    end

    // Next state, round-robin pointer and response tag
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        rsp0_d  = accept && !win;
        rsp1_d  = accept && win;
        if (accept) begin
            if (win_lock) begin
                state_d = win ? ST_LOCK1 : ST_LOCK0;
            end else begin
                state_d = ST_IDLE;
                rr_d    = ~win;
            end
        end
    end

`ifdef RFARB_R0_GUARD_EN
    // Remember which read lanes targeted register 0 so the response can be forced to zero
    always_comb begin
        zero1_d = accept && (win_raddr1 == '0);
        zero2_d = accept && (win_raddr2 == '0);
    end
`endif

    // Response data is the register file output, optionally zeroed per lane
    always_comb begin
        bus.rsp0_valid = rsp0_q;
        bus.rsp1_valid = rsp1_q;
`ifdef RFARB_R0_GUARD_EN
        bus.rsp_rdata1 = zero1_q ? '0 : bus.rf_r1_dout;
        bus.rsp_rdata2 = zero2_q ? '0 : bus.rf_r2_dout;
`else
        bus.rsp_rdata1 = bus.rf_r1_dout;
        bus.rsp_rdata2 = bus.rf_r2_dout;
`endif
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_q     <= 1'b0;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
            raddr1_q <= '0;
            raddr2_q <= '0;
`ifdef RFARB_R0_GUARD_EN
            zero1_q  <= 1'b0;
            zero2_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            rsp0_q   <= rsp0_d;
            rsp1_q   <= rsp1_d;
            raddr1_q <= raddr1_d;
            raddr2_q <= raddr2_d;
`ifdef RFARB_R0_GUARD_EN
            zero1_q  <= zero1_d;
            zero2_q  <= zero2_d;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed self-checking bench for regfile_arbiter
module tb_regfile_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    regfile_arbiter_if #(.AW(5), .DW(32)) bus ();

    regfile_arbiter #(.AW(5), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: negedge write, registered read ports
    logic [31:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    end
    always @(negedge clk) if (bus.rf_r3_wr) mem[bus.rf_r3_addr] <= bus.rf_r3_din;
    always @(posedge clk) begin
        bus.rf_r1_dout <= mem[bus.rf_r1_addr];
        bus.rf_r2_dout <= mem[bus.rf_r2_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_lock = 0;  bus.req1_lock = 0;
        bus.req0_we = 0;    bus.req1_we = 0;
        bus.req0_waddr = 0; bus.req1_waddr = 0;
        bus.req0_wdata = 0; bus.req1_wdata = 0;
        bus.req0_raddr1 = 0; bus.req0_raddr2 = 0;
        bus.req1_raddr1 = 0; bus.req1_raddr2 = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        bus.req0_valid = 1; bus.req1_valid = 1; bus.req0_we = 1; bus.req0_raddr1 = 7;
        tick(); tick();
        n_checks++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready0: got %b expected 0", bus.req0_ready); end
        n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready1: got %b expected 0", bus.req1_ready); end
        n_checks++; if (bus.rf_r3_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %b expected 0", bus.rf_r3_wr); end
        n_checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got %b%b expected 00", bus.rsp0_valid, bus.rsp1_valid); end
        n_checks++; if (bus.rf_r1_addr !== 5'd0) begin n_fail++; $display("FAIL rst_raddr: got %0d expected 0", bus.rf_r1_addr); end
        clear_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_write_read();
        bus.req0_valid = 1; bus.req0_we = 1; bus.req0_waddr = 5; bus.req0_wdata = 32'hDEADBEEF;
        bus.req0_raddr1 = 5; bus.req0_raddr2 = 7;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready0: got %b expected 1", bus.req0_ready); end
        n_checks++; if (bus.rf_r3_wr !== 1'b1) begin n_fail++; $display("FAIL wr_en: got %b expected 1", bus.rf_r3_wr); end
        n_checks++; if (bus.rf_r3_addr !== 5'd5 || bus.rf_r3_din !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_addr_din: got %0d %h expected 5 deadbeef", bus.rf_r3_addr, bus.rf_r3_din); end
        n_checks++; if (bus.rf_r1_addr !== 5'd5 || bus.rf_r2_addr !== 5'd7) begin n_fail++; $display("FAIL wr_raddr: got %0d %0d expected 5 7", bus.rf_r1_addr, bus.rf_r2_addr); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_valid: got %b%b expected 10", bus.rsp0_valid, bus.rsp1_valid); end
        n_checks++; if (bus.rsp_rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rdata1: got %h expected deadbeef", bus.rsp_rdata1); end
        n_checks++; if (bus.rsp_rdata2 !== 32'h1000_0007) begin n_fail++; $display("FAIL wr_rdata2: got %h expected 10000007", bus.rsp_rdata2); end
        n_checks++; if (bus.rf_r3_wr !== 1'b0) begin n_fail++; $display("FAIL idle_wr: got %b expected 0", bus.rf_r3_wr); end
        tick();
        n_checks++; if (bus.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_once: got %b expected 0", bus.rsp0_valid); end
        n_checks++; if (bus.rf_r1_addr !== 5'd5) begin n_fail++; $display("FAIL hold_raddr: got %0d expected 5", bus.rf_r1_addr); end
    endtask

    task automatic test_round_robin();
        logic exp_g;
        logic prev_g;
        // single req1 access moves the pointer back to requester 0
        bus.req1_valid = 1; bus.req1_raddr1 = 3;
        #1;
        n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL rr_single1: got %b expected 1", bus.req1_ready); end
        tick();
        bus.req0_valid = 1; bus.req0_raddr1 = 1;
        bus.req1_valid = 1; bus.req1_raddr1 = 2;
        #1;
        n_checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp_rdata1 !== 32'h1000_0003) begin n_fail++; $display("FAIL rr_single_rsp: got %b %h expected 1 10000003", bus.rsp1_valid, bus.rsp_rdata1); end
        exp_g = 1'b0;
        prev_g = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) #1;
            n_checks++; if (bus.req0_ready !== !exp_g || bus.req1_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d: got %b%b expected %b%b", i, bus.req0_ready, bus.req1_ready, !exp_g, exp_g); end
            if (i > 0) begin
                n_checks++; if (bus.rsp0_valid !== !prev_g || bus.rsp1_valid !== prev_g || bus.rsp_rdata1 !== (prev_g ? 32'h1000_0002 : 32'h1000_0001)) begin n_fail++; $display("FAIL rr_rsp%0d: got %b%b %h expected %b%b", i, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_rdata1, !prev_g, prev_g); end
            end
            tick();
            prev_g = exp_g;
            exp_g = ~exp_g;
        end
        clear_inputs();
        #1;
        n_checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp_rdata1 !== 32'h1000_0002) begin n_fail++; $display("FAIL rr_last_rsp: got %b%b %h expected 01 10000002", bus.rsp0_valid, bus.rsp1_valid, bus.rsp_rdata1); end
        tick();
    endtask

    task automatic test_lock();
        // req1 takes the lock alone, then keeps it for 3 accepts while req0 waits
        bus.req1_valid = 1; bus.req1_lock = 1; bus.req1_raddr1 = 8;
        #1;
        n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL lock_enter: got %b expected 1", bus.req1_ready); end
        tick();
        bus.req0_valid = 1; bus.req0_we = 1; bus.req0_waddr = 11; bus.req0_wdata = 32'h5555_AAAA; bus.req0_raddr1 = 11;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL lock_grant%0d: got %b%b expected 01", i, bus.req0_ready, bus.req1_ready); end
            tick();
        end
        // lock held, owner idle: nobody granted, nothing written
        bus.req1_valid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (bus.req0_ready !== 1'b0 || bus.rf_r3_wr !== 1'b0) begin n_fail++; $display("FAIL lock_hold%0d: got ready0=%b wr=%b expected 0 0", i, bus.req0_ready, bus.rf_r3_wr); end
            n_checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== (i == 0)) begin n_fail++; $display("FAIL lock_hold_rsp%0d: got %b%b expected 0%b", i, bus.rsp0_valid, bus.rsp1_valid, (i == 0)); end
            tick();
        end
        // release the lock
        bus.req1_valid = 1; bus.req1_lock = 0;
        #1;
        n_checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL lock_release: got %b%b expected 01", bus.req0_ready, bus.req1_ready); end
        tick();
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL after_unlock: got %b%b expected 10", bus.req0_ready, bus.req1_ready); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_rdata1 !== 32'h5555_AAAA) begin n_fail++; $display("FAIL unlock_rsp: got %b %h expected 1 5555aaaa", bus.rsp0_valid, bus.rsp_rdata1); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req0_valid = 1; bus.req0_lock = 1; bus.req0_raddr1 = 4;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL rm_accept: got %b expected 1", bus.req0_ready); end
        tick();
        rst_n = 0;
        bus.req0_lock = 0; bus.req0_we = 1; bus.req0_waddr = 9; bus.req0_wdata = 32'hBAD0BAD0;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b0 || bus.rf_r3_wr !== 1'b0) begin n_fail++; $display("FAIL rm_no_issue: got ready0=%b wr=%b expected 0 0", bus.req0_ready, bus.rf_r3_wr); end
        tick();
        n_checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rsp_cleared: got %b%b expected 00", bus.rsp0_valid, bus.rsp1_valid); end
        rst_n = 1;
        clear_inputs();
        bus.req1_valid = 1; bus.req1_raddr1 = 6; bus.req1_raddr2 = 9;
        #1;
        n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL rm_req1_grant: got %b expected 1", bus.req1_ready); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp_rdata1 !== 32'h1000_0006 || bus.rsp_rdata2 !== 32'h1000_0009) begin n_fail++; $display("FAIL rm_rsp: got %b %h %h expected 1 10000006 10000009", bus.rsp1_valid, bus.rsp_rdata1, bus.rsp_rdata2); end
        tick();
    endtask

    task automatic test_r0_guard();
        logic        exp_wr;
        logic [31:0] exp_d1;
`ifdef RFARB_R0_GUARD_EN
        exp_wr = 1'b0; exp_d1 = 32'h0;
`else
        exp_wr = 1'b1; exp_d1 = 32'h1234;
`endif
        bus.req0_valid = 1; bus.req0_we = 1; bus.req0_waddr = 0; bus.req0_wdata = 32'h1234;
        bus.req0_raddr1 = 0; bus.req0_raddr2 = 5;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1 || bus.rf_r3_wr !== exp_wr) begin n_fail++; $display("FAIL r0_wr: got ready=%b wr=%b expected 1 %b", bus.req0_ready, bus.rf_r3_wr, exp_wr); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_rdata1 !== exp_d1) begin n_fail++; $display("FAIL r0_rdata1: got %b %h expected 1 %h", bus.rsp0_valid, bus.rsp_rdata1, exp_d1); end
        n_checks++; if (bus.rsp_rdata2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL r0_rdata2: got %h expected deadbeef", bus.rsp_rdata2); end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_write_read();
        test_round_robin();
        test_lock();
        test_reset_mid();
        test_r0_guard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
